// File: rtl/tmds_encoder_if.sv
// Pixel-side bundle of one TMDS channel encoder: colour byte, data enable,
// control bits in and the 10-bit symbol out.
interface tmds_encoder_if;
    logic [7:0] i_data;
    logic       i_de;
    logic [1:0] i_ctrl;
    logic [9:0] o_tmds;

    modport master (output i_data, i_de, i_ctrl, input o_tmds);
    modport slave  (input i_data, i_de, i_ctrl, output o_tmds);
endinterface

// File: rtl/tmds_encoder.sv
// DVI/HDMI TMDS 8b/10b channel encoder: stage 1 builds the transition-minimised
// word, stage 2 balances DC disparity or emits a control token during blanking.
module tmds_encoder (
    input logic           clk,
    input logic           rst,
    tmds_encoder_if.slave bus
);
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        ones8 = 4'd0;
        for (int i = 0; i < 8; i++) ones8 = ones8 + {3'b000, v[i]};
    endfunction

    // Bit 8 records the chosen path (1 = XOR) so the decoder can undo it.
    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [3:0] n;
        logic       xnor_path;
        logic [8:0] q;
        n         = ones8(d);
        xnor_path = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q[0]      = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = xnor_path ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~xnor_path;
        return q;
    endfunction

    // ---------------- stage 1 ----------------
    logic [8:0] qm_d;
    logic [3:0] qm_ones_d;

    always_comb begin
        qm_d      = minimise(bus.i_data);
        qm_ones_d = ones8(qm_d[7:0]);
    end

    logic       de_q;
    logic [1:0] ctrl_q;
    logic [8:0] qm_q;
    logic [3:0] n1_q;
    logic [3:0] n0_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
            qm_q   <= 9'd0;
            n1_q   <= 4'd0;
            n0_q   <= 4'd0;
        end else begin
            de_q   <= bus.i_de;
            ctrl_q <= bus.i_ctrl;
            qm_q   <= qm_d;
            n1_q   <= qm_ones_d;
            n0_q   <= 4'd8 - qm_ones_d;
        end
    end

    // ---------------- stage 2 ----------------
    logic signed [4:0] cnt;
    logic signed [4:0] cnt_next;
    logic signed [4:0] diff;
    logic [9:0]        tmds_q;
    logic [9:0]        tmds_next;

    // NOTE: every output of this block gets a default first so no path
    // through the branches can infer a latch.
    always_comb begin
        tmds_next = CTRL_00;
        cnt_next  = 5'sd0;
        diff      = signed'({1'b0, n1_q}) - signed'({1'b0, n0_q});
        if (de_q) begin
            if ((cnt == 5'sd0) || (n1_q == n0_q)) begin
                tmds_next = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                cnt_next  = qm_q[8] ? (cnt + diff) : (cnt - diff);
            end else if ((!cnt[4] && (n1_q > n0_q)) || (cnt[4] && (n0_q > n1_q))) begin
                // Already leaning the same way as this word: invert to pull back.
                tmds_next = {1'b1, qm_q[8], ~qm_q[7:0]};
                cnt_next  = cnt + signed'({3'b000, qm_q[8], 1'b0}) - diff;
            end else begin
                tmds_next = {1'b0, qm_q[8], qm_q[7:0]};
                cnt_next  = cnt - signed'({3'b000, ~qm_q[8], 1'b0}) + diff;
            end
        end else begin
            case (ctrl_q)
                2'b00:   tmds_next = CTRL_00;
                2'b01:   tmds_next = CTRL_01;
                2'b10:   tmds_next = CTRL_10;
                default: tmds_next = CTRL_11;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 5'sd0;
            tmds_q <= CTRL_00;
        end else begin
            cnt    <= cnt_next;
            tmds_q <= tmds_next;
        end
    end

    assign bus.o_tmds = tmds_q;
endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
- REQ-001 The block SHALL have no parameters; every width and latency below is fixed.
- REQ-002 clk  input  1  pixel clock; the only clock.
- REQ-003 rst  input  1  reset, synchronous, active-high.
- REQ-004 i_data  input  8  one pixel colour channel (o_red, o_green or o_blue of gfx).
- REQ-005 i_de  input  1  data enable: 1 = active video, 0 = blanking.
- REQ-006 i_ctrl  input  2  control bits sent during blanking (C1,C0): {vsync,hsync} on the blue channel, 2'b00 on the others.
- REQ-007 o_tmds  output  10  encoded TMDS symbol, registered; bit 0 is transmitted first.

Function
- REQ-008 The encoder SHALL be a 2-stage pipeline: inputs sampled at rising edge n appear on o_tmds after rising edge n+1, so latency is 2 clocks and throughput is 1 symbol per clock.
- REQ-009 Stage 1 SHALL register i_de, i_ctrl, the 9-bit transition-minimised word q_m, and the ones and zeros counts of q_m[7:0].
- REQ-010 q_m selection: let N1 = number of ones in i_data. If N1>4, or N1==4 and i_data[0]==0, use the XNOR path; otherwise use the XOR path.
- REQ-011 Both paths SHALL set q_m[0] = i_data[0].
- REQ-012 XNOR path: q_m[i] = ~(q_m[i-1] ^ i_data[i]) for i = 1..7, and q_m[8] = 0.
- REQ-013 XOR path: q_m[i] = q_m[i-1] ^ i_data[i] for i = 1..7, and q_m[8] = 1.
- REQ-014 Stage 2 SHALL hold a signed running-disparity counter cnt, at least 5 bits wide; define n1/n0 as the ones/zeros counts of q_m[7:0].
- REQ-015 When de==1 and (cnt==0 or n1==n0), stage 2 SHALL output o_tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
- REQ-016 In the REQ-015 case, cnt SHALL update to cnt + (n1-n0) when q_m[8]==1, and to cnt + (n0-n1) when q_m[8]==0.
- REQ-017 Otherwise, when de==1 and ((cnt>0 and n1>n0) or (cnt<0 and n0>n1)), stage 2 SHALL output o_tmds = {1, q_m[8], ~q_m[7:0]} and set cnt = cnt + 2*q_m[8] + (n0-n1).
- REQ-018 Otherwise, when de==1, stage 2 SHALL output o_tmds = {0, q_m[8], q_m[7:0]} and set cnt = cnt - 2*(~q_m[8]) + (n1-n0).
- REQ-019 When de==0, o_tmds SHALL be the control token for the staged ctrl value: 00 -> 10'b1101010100, 01 -> 10'b0010101011, 10 -> 10'b0101010100, 11 -> 10'b1010101011.
- REQ-020 When de==0, cnt SHALL be 0 on the next clock.
- REQ-021 All arithmetic SHALL be signed, with n1 and n0 zero-extended to the cnt width; cnt SHALL NOT wrap for any legal input stream, since its magnitude is bounded by 10.
- REQ-022 DE transitions SHALL take effect on the exact symbol they accompany: the first active pixel after blanking is encoded with cnt==0, and the first blanking symbol is a control token.
- REQ-023 The block SHALL have no combinational path from any input to o_tmds.

Reset
- REQ-024 While rst==1 at a rising edge, the block SHALL clear all pipeline registers to de=0, ctrl=2'b00, q_m=0 and counts=0.
- REQ-025 While rst==1 at a rising edge, the block SHALL set cnt=0 and o_tmds=10'b1101010100.
- REQ-026 Reset asserted mid-stream SHALL discard in-flight symbols; o_tmds SHALL show 10'b1101010100 for 2 clocks after rst deasserts, and then symbols derived from the post-reset inputs.

Verification
- REQ-027 Reset: hold rst=1 for 3 clocks with random inputs -> o_tmds = 10'b1101010100 and cnt = 0 on every cycle; after release, o_tmds stays 10'b1101010100 for 2 clocks while de=0 and ctrl=00.
- REQ-028 Control tokens: de=0 with ctrl stepping 00, 01, 10, 11 on consecutive clocks -> o_tmds is 1101010100, 0010101011, 0101010100, 1010101011 starting 2 clocks later, one per clock.
- REQ-029 Disparity on a run of zeros: blanking, then i_data=0x00 with de=1 for 3 clocks -> o_tmds sequence 10'b0100000000 (cnt -8), 10'b1111111111 (cnt +2), 10'b0100000000 (cnt -6).
- REQ-030 XNOR path: blanking, then i_data=0xFF with de=1 -> o_tmds = 10'b1000000000 and cnt = -8.
- REQ-031 Blanking clears disparity: 0x00 for 1 clock, de=0 for 1 clock, then 0x00 again -> second data symbol is 10'b0100000000 (cnt restarted from 0).
- REQ-032 Random soak: 10^5 random symbols with random de, checked cycle-by-cycle against a reference model -> exact o_tmds match, |cnt| <= 10 always, and a reference decoder recovers every i_data and i_ctrl value.
